// File: rtl/edge_setup_ctrl.sv
// edge_setup_ctrl: frame and line scheduler for the edge-function rasteriser.
//
// Takes one triangle from the vertex stage into a shadow buffer and commits it
// at the start of vblank. It then computes the line-0 edge initial values with
// one shared multiplier, and advances them by b_i in every hblank. The
// rasteriser loads e*_init_t1 at x == H_LOAD.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   x, y                  VGA column / line counters
//   vtx_valid, vtx_ready  vertex handshake (ready = shadow buffer empty)
//   in_x0..in_y2          offered triangle (signed 20-bit)
//   x_screen_v*, y_screen_v*  active triangle, to the rasteriser
//   e0/e1/e2_init_t1      edge init values for the next line load
//   busy                  commit, setup or line update in progress
//   late_err              sticky: busy was still set at x == H_LOAD
//
// Optional feature: define BACKFACE_CULL_EN to add a signed-area test to
// SETUP. Triangles with area <= 0 force all e_init to 20'h80000 for the frame.
module edge_setup_ctrl #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned H_LOAD   = 799
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [9:0]         x,
    input  logic [9:0]         y,
    input  logic               vtx_valid,
    output logic               vtx_ready,
    input  logic signed [19:0] in_x0,
    input  logic signed [19:0] in_y0,
    input  logic signed [19:0] in_x1,
    input  logic signed [19:0] in_y1,
    input  logic signed [19:0] in_x2,
    input  logic signed [19:0] in_y2,
    output logic signed [19:0] x_screen_v0,
    output logic signed [19:0] y_screen_v0,
    output logic signed [19:0] x_screen_v1,
    output logic signed [19:0] y_screen_v1,
    output logic signed [19:0] x_screen_v2,
    output logic signed [19:0] y_screen_v2,
    output logic signed [19:0] e0_init_t1,
    output logic signed [19:0] e1_init_t1,
    output logic signed [19:0] e2_init_t1,
    output logic               busy,
    output logic               late_err
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_COMMIT = 2'd1;
    localparam logic [1:0] S_SETUP  = 2'd2;
    localparam logic [1:0] S_LINE   = 2'd3;

`ifdef BACKFACE_CULL_EN
    localparam logic [2:0] SETUP_LAST = 3'd7;
`else
    localparam logic [2:0] SETUP_LAST = 3'd5;
`endif

    localparam int unsigned V_LAST_I = V_ACTIVE - 1;
    localparam logic [9:0]  H_ACT    = H_ACTIVE[9:0];
    localparam logic [9:0]  V_ACT    = V_ACTIVE[9:0];
    localparam logic [9:0]  V_LAST   = V_LAST_I[9:0];
    localparam logic [9:0]  H_LD     = H_LOAD[9:0];

    logic               shadow_full;
    logic signed [19:0] sh_x0, sh_y0, sh_x1, sh_y1, sh_x2, sh_y2;

    logic [1:0] state_q, state_d, st;
    logic [2:0] step_q, step_d;
    logic       frame_trig, line_trig, line_en;

    logic signed [19:0] a0, a1, a2, b0, b1, b2;
    logic signed [19:0] mul_a, mul_b, prod;
    logic signed [19:0] acc_sel, acc_diff;
    logic signed [19:0] add_a, add_b, add_sum;

`ifdef BACKFACE_CULL_EN
    logic signed [19:0] dy20, area_q, area_sum;
    logic               culled_q;
    assign dy20     = y_screen_v2 - y_screen_v0;
    assign area_sum = area_q + prod;
    assign line_en  = !culled_q;
`else
    assign line_en  = 1'b1;
`endif

    assign vtx_ready  = !shadow_full;
    assign frame_trig = (y == V_ACT) && (x == 10'd0);
    assign line_trig  = (y < V_LAST) && (x == H_ACT);

    // Edge i runs vi -> vj, j = (i+1) mod 3.
    assign a0 = y_screen_v1 - y_screen_v0;
    assign a1 = y_screen_v2 - y_screen_v1;
    assign a2 = y_screen_v0 - y_screen_v2;
    assign b0 = x_screen_v0 - x_screen_v1;
    assign b1 = x_screen_v1 - x_screen_v2;
    assign b2 = x_screen_v2 - x_screen_v0;

    // The trigger cycle itself is the first COMMIT / LINE_UPD cycle, so busy
    // covers exactly the columns in which work happens.
    always_comb begin
        st = state_q;
        if (state_q == S_IDLE) begin
            if (frame_trig) begin
                st = S_COMMIT;
            end else if (line_trig) begin
                st = S_LINE;
            end
        end
    end

    assign busy = (st != S_IDLE);

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        case (st)
            S_COMMIT: begin
                state_d = S_SETUP;
                step_d  = 3'd0;
            end
            S_SETUP: begin
                state_d = S_SETUP;
                if (step_q == SETUP_LAST) begin
                    state_d = S_IDLE;
                    step_d  = 3'd0;
                end else begin
                    step_d = step_q + 3'd1;
                end
            end
            S_LINE: begin
                state_d = S_LINE;
                if (step_q == 3'd2) begin
                    state_d = S_IDLE;
                    step_d  = 3'd0;
                end else begin
                    step_d = step_q + 3'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                step_d  = 3'd0;
            end
        endcase
    end

    // Shared multiplier operand select; the product keeps only the low 20 bits.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (step_q)
            3'd0: begin mul_a = x_screen_v0; mul_b = a0; end
            3'd1: begin mul_a = y_screen_v0; mul_b = b0; end
            3'd2: begin mul_a = x_screen_v1; mul_b = a1; end
            3'd3: begin mul_a = y_screen_v1; mul_b = b1; end
            3'd4: begin mul_a = x_screen_v2; mul_b = a2; end
            3'd5: begin mul_a = y_screen_v2; mul_b = b2; end
`ifdef BACKFACE_CULL_EN
            3'd6: begin mul_a = b2;          mul_b = a0; end
            3'd7: begin mul_a = dy20;        mul_b = b0; end
`endif
            default: ;
        endcase
    end

    assign prod = mul_a * mul_b;

    always_comb begin
        case (step_q[2:1])
            2'd0:    acc_sel = e0_init_t1;
            2'd1:    acc_sel = e1_init_t1;
            default: acc_sel = e2_init_t1;
        endcase
    end

    assign acc_diff = acc_sel - prod;

    always_comb begin
        case (step_q[1:0])
            2'd0:    begin add_a = e0_init_t1; add_b = b0; end
            2'd1:    begin add_a = e1_init_t1; add_b = b1; end
            default: begin add_a = e2_init_t1; add_b = b2; end
        endcase
    end

    assign add_sum = add_a + add_b;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            step_q      <= 3'd0;
            shadow_full <= 1'b0;
            sh_x0 <= '0; sh_y0 <= '0; sh_x1 <= '0;
            sh_y1 <= '0; sh_x2 <= '0; sh_y2 <= '0;
            x_screen_v0 <= '0; y_screen_v0 <= '0; x_screen_v1 <= '0;
            y_screen_v1 <= '0; x_screen_v2 <= '0; y_screen_v2 <= '0;
            e0_init_t1  <= '0;
            e1_init_t1  <= '0;
            e2_init_t1  <= '0;
            late_err    <= 1'b0;
`ifdef BACKFACE_CULL_EN
            area_q      <= '0;
            culled_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            step_q  <= step_d;

            if (vtx_valid && !shadow_full) begin
                sh_x0 <= in_x0; sh_y0 <= in_y0; sh_x1 <= in_x1;
                sh_y1 <= in_y1; sh_x2 <= in_x2; sh_y2 <= in_y2;
                shadow_full <= 1'b1;
            end

            if (busy && (x == H_LD)) begin
                late_err <= 1'b1;
            end

            case (st)
                S_COMMIT: begin
                    // Commit and a new transfer are exclusive: transfers need an empty shadow.
                    if (shadow_full) begin
                        x_screen_v0 <= sh_x0; y_screen_v0 <= sh_y0;
                        x_screen_v1 <= sh_x1; y_screen_v1 <= sh_y1;
                        x_screen_v2 <= sh_x2; y_screen_v2 <= sh_y2;
                        shadow_full <= 1'b0;
                    end
                    e0_init_t1 <= '0;
                    e1_init_t1 <= '0;
                    e2_init_t1 <= '0;
                end
                S_SETUP: begin
                    case (step_q[2:1])
                        2'd0: e0_init_t1 <= acc_diff;
                        2'd1: e1_init_t1 <= acc_diff;
                        2'd2: e2_init_t1 <= acc_diff;
                        default: begin
`ifdef BACKFACE_CULL_EN
                            if (!step_q[0]) begin
                                area_q <= prod;
                            end else if (area_sum <= 20'sd0) begin
                                e0_init_t1 <= 20'h80000;
                                e1_init_t1 <= 20'h80000;
                                e2_init_t1 <= 20'h80000;
                                culled_q   <= 1'b1;
                            end else begin
                                culled_q   <= 1'b0;
                            end
`endif
                        end
                    endcase
                end
                S_LINE: begin
                    if (line_en) begin
                        case (step_q[1:0])
                            2'd0:    e0_init_t1 <= add_sum;
                            2'd1:    e1_init_t1 <= add_sum;
                            default: e2_init_t1 <= add_sum;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
